// File: rtl/sclk_mon_pkg.sv
// Shared types and default sizing for the slow-clock monitor.
package sclk_mon_pkg;

  typedef enum logic [2:0] {
    ACQ0  = 3'd0,
    ACQ1  = 3'd1,
    ACQ2  = 3'd2,
    LOCK  = 3'd3,
    STALL = 3'd4
  } state_t;

  localparam int CNT_W_DEF       = 32;
  localparam int TIMEOUT_DEF     = 1_000_000;
  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/sync_edge_det.sv
// Brings an asynchronous level into the clk domain and flags its synced edges.
// rise_o/fall_o are combinational from the last sync stage and its one-cycle-delayed copy.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;
  logic                   s_w;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sclk_i};
    s_w    = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= s_w;
    end
  end

  assign rise_o = s_w & ~prev_q;
  assign fall_o = ~s_w & prev_q;

endmodule

// File: rtl/sclk_monitor.sv
// Receive side of the clock divider: edge ticks, half-period/period measurement and stall flag on clk.
// All outputs registered; a synced sclk edge shows on the outputs the cycle after it is detected.
module sclk_monitor
  import sclk_mon_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk_in,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic [CNT_W-1:0] half_period,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             stalled,
  output logic [15:0]      edge_count
);

  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
  localparam logic [CNT_W-1:0] TMO_C    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_M1_C = CNT_W'(TIMEOUT - 1);

  logic             rise_w;
  logic             fall_w;
  logic             edge_w;
  logic             timeout_w;
  logic [CNT_W-1:0] meas_w;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] half_cnt_q, half_cnt_d;
  logic [CNT_W-1:0] half_period_q, half_period_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             stalled_q, stalled_d;
  logic             rise_q, fall_q;
  logic [15:0]      edge_count_q, edge_count_d;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .sclk_i (sclk_in),
    .rise_o (rise_w),
    .fall_o (fall_w)
  );

  always_comb begin
    edge_w        = rise_w | fall_w;
    meas_w        = half_cnt_q + ONE_C;
    // A coincident edge completes a valid half, so it pre-empts the timeout.
    timeout_w     = !edge_w && (half_cnt_q == TMO_M1_C);

    state_d       = state_q;
    half_period_d = half_period_q;
    period_d      = period_q;
    valid_d       = valid_q;
    stalled_d     = stalled_q;
    edge_count_d  = edge_count_q;

    if (edge_w) begin
      half_cnt_d = '0;
    end else if (half_cnt_q == TMO_C) begin
      half_cnt_d = half_cnt_q;
    end else begin
      half_cnt_d = meas_w;
    end

    if (rise_w) begin
      edge_count_d = edge_count_q + 16'd1;
    end

    case (state_q)
      ACQ0: begin
        if (edge_w) state_d = ACQ1;
      end
      ACQ1: begin
        if (edge_w) begin
          state_d       = ACQ2;
          half_period_d = meas_w;
        end
      end
      ACQ2, LOCK: begin
        if (edge_w) begin
          state_d       = LOCK;
          half_period_d = meas_w;
          period_d      = meas_w + half_period_q;
          valid_d       = 1'b1;
        end
      end
      STALL: begin
        if (edge_w) begin
          state_d   = ACQ1;
          stalled_d = 1'b0;
        end
      end
      default: state_d = ACQ0;
    endcase

    if (timeout_w) begin
      state_d   = STALL;
      stalled_d = 1'b1;
      valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ACQ0;
      half_cnt_q    <= '0;
      half_period_q <= '0;
      period_q      <= '0;
      valid_q       <= 1'b0;
      stalled_q     <= 1'b0;
      rise_q        <= 1'b0;
      fall_q        <= 1'b0;
      edge_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      half_cnt_q    <= half_cnt_d;
      half_period_q <= half_period_d;
      period_q      <= period_d;
      valid_q       <= valid_d;
      stalled_q     <= stalled_d;
      rise_q        <= rise_w;
      fall_q        <= fall_w;
      edge_count_q  <= edge_count_d;
    end
  end

  assign rise_tick    = rise_q;
  assign fall_tick    = fall_q;
  assign half_period  = half_period_q;
  assign period       = period_q;
  assign period_valid = valid_q;
  assign stalled      = stalled_q;
  assign edge_count   = edge_count_q;

endmodule
